// File: rtl/sudoku_pkg.sv
// Shared row-level definitions: grid length, cursor width, sequencer state
// encoding and one-hot <-> index helpers.
package sudoku_pkg;

   localparam int GRID_LEN = 9;
   localparam int CURSOR_W = $clog2(GRID_LEN);

   typedef enum logic [4:0] {
      S_IDLE  = 5'b00001,
      S_GRANT = 5'b00010,
      S_WAIT  = 5'b00100,
      S_FWD   = 5'b01000,
      S_BAK   = 5'b10000
   } row_seq_state_t;

   // Lowest set bit wins, so a multi-hot input still yields a defined index.
   function automatic logic [CURSOR_W-1:0] onehot_to_idx(input logic [GRID_LEN-1:0] oh);
      logic [CURSOR_W-1:0] idx;
      idx = '0;
      for (int i = GRID_LEN - 1; i >= 0; i--) begin
         if (oh[i]) idx = CURSOR_W'(i);
      end
      return idx;
   endfunction

   function automatic logic [GRID_LEN-1:0] idx_to_onehot(input logic [CURSOR_W-1:0] idx);
      logic [GRID_LEN-1:0] one;
      one = GRID_LEN'(1);
      return one << idx;
   endfunction

endpackage

// File: rtl/row_bias_mem.sv
// Per-row bias memory: LEN one-hot entries, identity after reset, bulk load,
// and a registered one-hot-indexed read that returns 1<<LEN for an empty index.
module row_bias_mem
   import sudoku_pkg::*;
#(
   parameter int LEN = GRID_LEN
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load_en,
   input  logic [LEN*LEN-1:0] load_data,
   input  logic               rd_en,
   input  logic [LEN-1:0]     rd_index,
   output logic [LEN:0]       rd_data
);

   logic [LEN-1:0] mem_q [LEN];
   logic [LEN-1:0] mem_d [LEN];
   logic [LEN:0]   rd_data_q;
   logic [LEN:0]   rd_data_d;

   always_comb begin
      for (int i = 0; i < LEN; i++) begin
         mem_d[i] = load_en ? load_data[i*LEN +: LEN] : mem_q[i];
      end
      rd_data_d = rd_data_q;
      if (rd_en) begin
         if (rd_index == '0) rd_data_d = {1'b1, {LEN{1'b0}}};
         else                rd_data_d = {1'b0, mem_q[onehot_to_idx(rd_index)]};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LEN; i++) begin
            mem_q[i] <= idx_to_onehot(CURSOR_W'(i));
         end
         rd_data_q <= '0;
      end else begin
         for (int i = 0; i < LEN; i++) begin
            mem_q[i] <= mem_d[i];
         end
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/row_sequencer.sv
// Row controller: walks the single myturn token across the row's tiles,
// serves bias requests from the cursor tile and builds each tile's occup_mask.
module row_sequencer
   import sudoku_pkg::*;
#(
   parameter int LEN = GRID_LEN
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               row_turn,
   input  logic               row_dir,
   output logic               row_passfwd,
   output logic               row_passbak,
   input  logic               bias_load,
   input  logic [LEN*LEN-1:0] bias_wdata,
   output logic [LEN-1:0]     tile_myturn,
   input  logic [LEN-1:0]     tile_passfwd,
   input  logic [LEN-1:0]     tile_passbak,
   input  logic [LEN-1:0]     tile_rq,
   input  logic [LEN*LEN-1:0] tile_index,
   output logic [LEN:0]       value_test,
   input  logic [LEN*LEN-1:0] tile_value,
   input  logic [LEN*LEN-1:0] col_mask,
   output logic [LEN*LEN-1:0] occup_mask
);

   localparam logic [CURSOR_W-1:0] LAST = CURSOR_W'(LEN - 1);

   row_seq_state_t      state_q, state_d;
   logic [CURSOR_W-1:0] cursor_q, cursor_d;
   logic                load_en;
   logic [LEN-1:0]      acc;

   always_comb begin
      state_d     = state_q;
      cursor_d    = cursor_q;
      tile_myturn = '0;
      row_passfwd = 1'b0;
      row_passbak = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (row_turn) begin
               cursor_d = row_dir ? LAST : '0;
               state_d  = S_GRANT;
            end
         end
         S_GRANT: begin
            tile_myturn = idx_to_onehot(cursor_q);
            state_d     = S_WAIT;
         end
         S_WAIT: begin
            // Backtrack has priority when the tile raises both pass lines.
            if (tile_passbak[cursor_q]) begin
               if (cursor_q == '0) begin
                  state_d = S_BAK;
               end else begin
                  cursor_d = cursor_q - 1'b1;
                  state_d  = S_GRANT;
               end
            end else if (tile_passfwd[cursor_q]) begin
               if (cursor_q == LAST) begin
                  state_d = S_FWD;
               end else begin
                  cursor_d = cursor_q + 1'b1;
                  state_d  = S_GRANT;
               end
            end
         end
         S_FWD: begin
            row_passfwd = 1'b1;
            state_d     = S_IDLE;
         end
         S_BAK: begin
            row_passbak = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cursor_q <= '0;
      end else begin
         state_q  <= state_d;
         cursor_q <= cursor_d;
      end
   end

   // A coincident row_turn takes the row out of IDLE, so the load is dropped.
   assign load_en = (state_q == S_IDLE) && bias_load && !row_turn;

   row_bias_mem #(.LEN(LEN)) u_bias_mem (
      .clock     (clock),
      .reset     (reset),
      .load_en   (load_en),
      .load_data (bias_wdata),
      .rd_en     (tile_rq[cursor_q]),
      .rd_index  (tile_index[cursor_q*LEN +: LEN]),
      .rd_data   (value_test)
   );

   // Only tiles to the left constrain tile t; later tiles are empty or will be redone.
   always_comb begin
      occup_mask = '0;
      acc        = '0;
      for (int t = 0; t < LEN; t++) begin
         occup_mask[t*LEN +: LEN] = col_mask[t*LEN +: LEN] | acc;
         acc                      = acc | tile_value[t*LEN +: LEN];
      end
   end

endmodule

// File: tb/tb_row_sequencer.sv
// Directed and randomized bench for row_sequencer, checked each cycle against
// a token-walk reference model of the row.
module tb_row_sequencer;

   localparam int N = 9;

   logic           clock = 1'b0;
   logic           reset;
   logic           row_turn, row_dir, bias_load;
   logic           row_passfwd, row_passbak;
   logic [N*N-1:0] bias_wdata;
   logic [N-1:0]   tile_myturn, tile_passfwd, tile_passbak, tile_rq;
   logic [N*N-1:0] tile_index, tile_value, col_mask, occup_mask;
   logic [N:0]     value_test;

   int errors = 0;
   int checks = 0;

   // Reference model: who holds the row, whether the token is being handed
   // over this cycle, which row-level pulse is pending, and the bias table
   // held as value positions.
   int         m_cur;
   bit         m_active;
   bit         m_granting;
   int         m_exit;
   int         m_mem [N];
   logic [N:0] m_vt;

   row_sequencer #(.LEN(N)) dut (
      .clock        (clock),
      .reset        (reset),
      .row_turn     (row_turn),
      .row_dir      (row_dir),
      .row_passfwd  (row_passfwd),
      .row_passbak  (row_passbak),
      .bias_load    (bias_load),
      .bias_wdata   (bias_wdata),
      .tile_myturn  (tile_myturn),
      .tile_passfwd (tile_passfwd),
      .tile_passbak (tile_passbak),
      .tile_rq      (tile_rq),
      .tile_index   (tile_index),
      .value_test   (value_test),
      .tile_value   (tile_value),
      .col_mask     (col_mask),
      .occup_mask   (occup_mask)
   );

   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic int lowestBit(input logic [N-1:0] v);
      int p;
      p = -1;
      for (int b = N - 1; b >= 0; b--) if (v[b]) p = b;
      return p;
   endfunction

   task automatic modelReset();
      m_cur      = 0;
      m_active   = 0;
      m_granting = 0;
      m_exit     = 0;
      m_vt       = '0;
      for (int i = 0; i < N; i++) m_mem[i] = i;
   endtask

   // Advances the model across one rising edge using the inputs present before it.
   task automatic modelEdge();
      int p;
      logic [N:0] one;
      one = 1;
      if (tile_rq[m_cur]) begin
         p    = lowestBit(tile_index[m_cur*N +: N]);
         m_vt = (p < 0) ? (one << N) : (one << m_mem[p]);
      end
      if (!m_active && m_exit == 0) begin
         if (row_turn) begin
            m_cur      = row_dir ? N - 1 : 0;
            m_active   = 1;
            m_granting = 1;
         end else if (bias_load) begin
            for (int i = 0; i < N; i++) m_mem[i] = lowestBit(bias_wdata[i*N +: N]);
         end
      end else if (m_exit != 0) begin
         m_exit = 0;
      end else if (m_granting) begin
         m_granting = 0;
      end else if (tile_passbak[m_cur]) begin
         if (m_cur == 0) begin
            m_active = 0;
            m_exit   = 2;
         end else begin
            m_cur      = m_cur - 1;
            m_granting = 1;
         end
      end else if (tile_passfwd[m_cur]) begin
         if (m_cur == N - 1) begin
            m_active = 0;
            m_exit   = 1;
         end else begin
            m_cur      = m_cur + 1;
            m_granting = 1;
         end
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [N-1:0]   em;
      logic [N*N-1:0] eo;
      em = '0;
      if (m_active && m_granting) em[m_cur] = 1'b1;
      for (int t = 0; t < N; t++) begin
         for (int v = 0; v < N; v++) begin
            eo[t*N+v] = col_mask[t*N+v];
            for (int j = 0; j < t; j++) eo[t*N+v] = eo[t*N+v] | tile_value[j*N+v];
         end
      end
      checks++;
      assert (tile_myturn === em) else begin
         errors++;
         $error("[TB] FAIL %s myturn got %b want %b", tag, tile_myturn, em);
      end
      checks++;
      assert (row_passfwd === (m_exit == 1)) else begin
         errors++;
         $error("[TB] FAIL %s row_passfwd got %b want %b", tag, row_passfwd, m_exit == 1);
      end
      checks++;
      assert (row_passbak === (m_exit == 2)) else begin
         errors++;
         $error("[TB] FAIL %s row_passbak got %b want %b", tag, row_passbak, m_exit == 2);
      end
      checks++;
      assert (value_test === m_vt) else begin
         errors++;
         $error("[TB] FAIL %s value_test got %b want %b", tag, value_test, m_vt);
      end
      checks++;
      assert (occup_mask === eo) else begin
         errors++;
         $error("[TB] FAIL %s occup_mask got %h want %h", tag, occup_mask, eo);
      end
   endtask

   task automatic applyStimulus(input string tag);
      @(posedge clock);
      modelEdge();
      #1;
      checkOutput(tag);
   endtask

   task automatic expectBits(input string tag, input logic [N:0] got, input logic [N:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("[TB] FAIL %s got %b want %b", tag, got, want);
      end
   endtask

   task automatic clearInputs();
      row_turn     = 0;
      row_dir      = 0;
      bias_load    = 0;
      bias_wdata   = '0;
      tile_passfwd = '0;
      tile_passbak = '0;
      tile_rq      = '0;
      tile_index   = '0;
      tile_value   = '0;
      col_mask     = '0;
   endtask

   initial begin
      clearInputs();
      reset = 1'b1;
      modelReset();
      #12;
      checkOutput("reset");
      @(negedge clock);
      reset = 1'b0;

      // Enter forward, grant tile 0.
      row_turn = 1; row_dir = 0;
      applyStimulus("turn_fwd");
      row_turn = 0;
      expectBits("first_grant", {1'b0, tile_myturn}, 10'b0000000001);

      // Identity table replies and the exhausted sentinel.
      tile_rq[0] = 1; tile_index[0 +: N] = 9'b000000100;
      applyStimulus("rq_idx2");
      expectBits("identity_reply", value_test, 10'b0000000100);
      tile_index[0 +: N] = '0;
      applyStimulus("rq_empty");
      expectBits("sentinel_reply", value_test, 10'b1000000000);
      tile_rq = '0;

      // Walk the token forward across the whole row.
      for (int t = 0; t < N; t++) begin
         tile_passfwd[t] = 1;
         applyStimulus("walk_fwd");
         tile_passfwd = '0;
         if (t < N - 1) applyStimulus("walk_wait");
      end
      expectBits("row_passfwd_hi", {9'b0, row_passfwd}, 10'd1);
      applyStimulus("fwd_exit");
      expectBits("row_passfwd_lo", {9'b0, row_passfwd}, 10'd0);

      // Forward to tile 3, then back all the way out of the row.
      row_turn = 1; row_dir = 0;
      applyStimulus("turn_fwd2");
      row_turn = 0;
      applyStimulus("wait0");
      for (int t = 0; t < 3; t++) begin
         tile_passfwd[t] = 1;
         applyStimulus("to3");
         tile_passfwd = '0;
         applyStimulus("to3_wait");
      end
      tile_passbak[3] = 1;
      applyStimulus("bak3");
      tile_passbak = '0;
      expectBits("bak_to_tile2", {1'b0, tile_myturn}, 10'b0000000100);
      applyStimulus("wait2");
      for (int t = 2; t >= 0; t--) begin
         tile_passbak[t] = 1;
         applyStimulus("bak_walk");
         tile_passbak = '0;
         if (t > 0) applyStimulus("bak_wait");
      end
      expectBits("row_passbak_hi", {9'b0, row_passbak}, 10'd1);
      applyStimulus("bak_exit");
      repeat (3) applyStimulus("idle_quiet");

      // Reversed permutation load while idle.
      for (int i = 0; i < N; i++) bias_wdata[i*N +: N] = 9'(1) << (N - 1 - i);
      bias_load = 1;
      applyStimulus("load_rev");
      bias_load = 0;
      tile_rq[0] = 1; tile_index[0 +: N] = 9'b000000001;
      applyStimulus("rq_rev");
      expectBits("reversed_reply", value_test, 10'b0100000000);
      tile_rq = '0;

      // Load attempted outside IDLE must not take effect.
      row_turn = 1; row_dir = 1;
      applyStimulus("turn_bak");
      row_turn = 0;
      applyStimulus("wait8");
      for (int i = 0; i < N; i++) bias_wdata[i*N +: N] = 9'(1) << i;
      bias_load = 1;
      applyStimulus("load_in_wait");
      bias_load = 0;
      tile_rq[8] = 1; tile_index[8*N +: N] = 9'b000000001;
      applyStimulus("rq_after_load");
      expectBits("load_ignored", value_test, 10'b0100000000);
      tile_rq = '0;

      // Back down to tile 2, then foreign and simultaneous pass pulses.
      for (int t = 8; t >= 3; t--) begin
         tile_passbak[t] = 1;
         applyStimulus("down");
         tile_passbak = '0;
         applyStimulus("down_wait");
      end
      tile_passfwd[5] = 1;
      applyStimulus("foreign_pass");
      tile_passfwd = '0;
      expectBits("foreign_ignored", {1'b0, tile_myturn}, 10'b0);
      tile_passfwd[2] = 1; tile_passbak[2] = 1;
      applyStimulus("both_pass");
      tile_passfwd = '0; tile_passbak = '0;
      expectBits("bak_wins", {1'b0, tile_myturn}, 10'b0000000010);
      applyStimulus("wait1");

      // Asynchronous reset in the middle of a search.
      #2;
      reset = 1'b1;
      #1;
      modelReset();
      checkOutput("async_reset");
      @(negedge clock);
      reset = 1'b0;
      tile_rq[0] = 1; tile_index[0 +: N] = 9'b000000001;
      applyStimulus("rq_after_reset");
      expectBits("identity_restored", value_test, 10'b0000000001);
      tile_rq = '0;

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         row_turn     = ($urandom_range(0, 7) == 0);
         row_dir      = 1'($urandom);
         bias_load    = ($urandom_range(0, 15) == 0);
         tile_passfwd = 9'($urandom);
         tile_passbak = 9'($urandom & $urandom & $urandom);
         tile_rq      = 9'($urandom);
         for (int t = 0; t < N; t++) begin
            bias_wdata[t*N +: N] = 9'(1) << $urandom_range(0, N - 1);
            case ($urandom_range(0, 3))
               0:       tile_index[t*N +: N] = '0;
               1:       tile_index[t*N +: N] = 9'($urandom);
               default: tile_index[t*N +: N] = 9'(1) << $urandom_range(0, N - 1);
            endcase
            tile_value[t*N +: N] = ($urandom_range(0, 2) == 0) ? 9'b0 : 9'(1) << $urandom_range(0, N - 1);
            col_mask[t*N +: N]   = 9'($urandom);
         end
         #1;
         checkOutput("rand_comb");
         applyStimulus("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
